// File: rtl/div_share_arbiter_if.sv
// Client- and divider-facing signals of div_share_arbiter.
// slave: arbiter side; master: the clients plus the divider instance.
interface div_share_arbiter_if #(
  parameter int WIDTH = 10
);
  logic [1:0]       req;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [1:0]       gnt;
  logic [1:0]       rsp_valid;
  logic [WIDTH-1:0] rsp_q;
  logic             rsp_ov;
  logic             rsp_dvz;
  logic             rsp_tmo;
  logic             busy;
  logic             div_rst;
  logic             div_loading_done;
  logic             div_start;
  logic             div_ld_a;
  logic             div_ld_b;
  logic [WIDTH-1:0] div_a;
  logic [WIDTH-1:0] div_b;
  logic [WIDTH-1:0] div_q;
  logic             div_ov;
  logic             div_dvz;
  logic             div_done;

  modport slave (
    input  req, a0, b0, a1, b1, div_q, div_ov, div_dvz, div_done,
    output gnt, rsp_valid, rsp_q, rsp_ov, rsp_dvz, rsp_tmo, busy,
           div_rst, div_loading_done, div_start, div_ld_a, div_ld_b, div_a, div_b
  );

  modport master (
    output req, a0, b0, a1, b1, div_q, div_ov, div_dvz, div_done,
    input  gnt, rsp_valid, rsp_q, rsp_ov, rsp_dvz, rsp_tmo, busy,
           div_rst, div_loading_done, div_start, div_ld_a, div_ld_b, div_a, div_b
  );
endinterface

// File: rtl/div_share_arbiter.sv
// Round-robin sharing of one fixed_point_division unit between two requesters,
// with load/start sequencing, a completion watchdog and registered responses.
module div_share_arbiter #(
  parameter int WIDTH   = 10,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input logic              clk,
  input logic              rst,
  div_share_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic             rr_ptr;
  logic             win;
  logic [CNT_W-1:0] wdog;

  logic             pick;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  always_comb begin
    pick  = (bus.req == 2'b11) ? rr_ptr : bus.req[1];
    sel_a = pick ? bus.a1 : bus.a0;
    sel_b = pick ? bus.b1 : bus.b0;
  end

  // All outputs are registered: each state's strobes are set on the edge that
  // leaves the previous state, so they are visible while the state is occupied+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= S_IDLE;
      rr_ptr               <= 1'b0;
      win                  <= 1'b0;
      wdog                 <= '0;
      bus.div_a            <= '0;
      bus.div_b            <= '0;
      bus.gnt              <= '0;
      bus.rsp_valid        <= '0;
      bus.rsp_q            <= '0;
      bus.rsp_ov           <= 1'b0;
      bus.rsp_dvz          <= 1'b0;
      bus.rsp_tmo          <= 1'b0;
      bus.busy             <= 1'b0;
      bus.div_rst          <= 1'b1;
      bus.div_loading_done <= 1'b0;
      bus.div_start        <= 1'b0;
      bus.div_ld_a         <= 1'b0;
      bus.div_ld_b         <= 1'b0;
    end else begin
      bus.gnt       <= '0;
      bus.rsp_valid <= '0;
      bus.div_rst   <= 1'b0;
      bus.div_start <= 1'b0;
      bus.div_ld_a  <= 1'b0;
      bus.div_ld_b  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.req != 2'b00) begin
            bus.div_a <= sel_a;
            bus.div_b <= sel_b;
            win       <= pick;
            bus.gnt   <= {pick, ~pick};
            rr_ptr    <= ~pick;
            bus.busy  <= 1'b1;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          bus.div_ld_a <= 1'b1;
          bus.div_ld_b <= 1'b1;
          state        <= S_START;
        end
        S_START: begin
          bus.div_loading_done <= 1'b1;
          bus.div_start        <= 1'b1;
          wdog                 <= '0;
          state                <= S_WAIT;
        end
        S_WAIT: begin
          wdog <= wdog + 1'b1;
          // Completion is checked first so a done on the last watchdog cycle still wins.
          if (bus.div_done) begin
            bus.rsp_q            <= bus.div_q;
            bus.rsp_ov           <= bus.div_ov;
            bus.rsp_dvz          <= bus.div_dvz;
            bus.rsp_tmo          <= 1'b0;
            bus.rsp_valid        <= {win, ~win};
            bus.div_loading_done <= 1'b0;
            state                <= S_RESP;
          end else if (wdog == WD_LAST) begin
            bus.rsp_q            <= '0;
            bus.rsp_ov           <= 1'b0;
            bus.rsp_dvz          <= 1'b0;
            bus.rsp_tmo          <= 1'b1;
            bus.rsp_valid        <= {win, ~win};
            bus.div_rst          <= 1'b1;
            bus.div_loading_done <= 1'b0;
            state                <= S_RESP;
          end
        end
        S_RESP: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          bus.busy             <= 1'b0;
          bus.div_loading_done <= 1'b0;
          state                <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_share_arbiter.sv
// Bench for div_share_arbiter: divider stub, transaction-level monitor with a
// response scoreboard, a vector table, hand-written corner sequences and random traffic.
module tb_div_share_arbiter;
  localparam int W   = 10;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_share_arbiter_if #(.WIDTH(W)) bus ();

  div_share_arbiter #(.WIDTH(W), .TIMEOUT(TMO), .CNT_W(7)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s (no response within bound)", nm);
  endtask

  // Divider stub: done pulses L cycles after start; q = a - b; ov = a < b; dvz = (b == 0).
  int stub_L   = 5;
  int stub_cnt = 0;
  bit stub_run = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst || bus.div_rst || bus.div_ld_a) begin
      stub_run <= 1'b0;
      stub_cnt <= 0;
    end else if (bus.div_start) begin
      stub_run <= 1'b1;
      stub_cnt <= 1;
    end else if (stub_run) begin
      if (stub_cnt == stub_L) stub_run <= 1'b0;
      else stub_cnt <= stub_cnt + 1;
    end
  end
  assign bus.div_done = stub_run && (stub_cnt == stub_L);
  assign bus.div_q    = bus.div_a - bus.div_b;
  assign bus.div_ov   = (bus.div_a < bus.div_b);
  assign bus.div_dvz  = (bus.div_b == '0);

  // Monitor: predicts winner, latency and response for every grant.
  typedef struct {
    int           idx;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           st_cyc;
    int           rsp_cyc;
    bit           tmo;
  } txn_t;
  txn_t pend[$];
  logic [1:0]   prev_req = '0;
  logic [W-1:0] pa0, pb0, pa1, pb1;
  int           pref = 0;

  always @(negedge clk) begin
    txn_t         t;
    int           w;
    logic [W-1:0] eq;
    if (rst) begin
      pend.delete();
      pref = 0;
    end else begin
      if (bus.gnt != 2'b00) begin
        w = (prev_req == 2'b11) ? pref : ((prev_req == 2'b10) ? 1 : 0);
        check("mon_gnt_has_req", 32'(prev_req != 2'b00), 32'd1);
        check("mon_gnt", 32'(bus.gnt), (w == 1) ? 32'd2 : 32'd1);
        t.idx     = w;
        t.a       = (w == 1) ? pa1 : pa0;
        t.b       = (w == 1) ? pb1 : pb0;
        t.st_cyc  = cyc + 2;
        t.tmo     = (stub_L > TMO - 1);
        t.rsp_cyc = t.tmo ? t.st_cyc + TMO : t.st_cyc + stub_L + 1;
        pend.push_back(t);
        pref = 1 - w;
      end
      if (bus.div_start) begin
        if (pend.size() == 0) fail("mon_start_unexpected");
        else check("mon_start_lat", 32'(cyc), 32'(pend[pend.size()-1].st_cyc));
      end
      check("mon_busy", 32'(bus.busy), 32'(pend.size() != 0));
      if (bus.rsp_valid != 2'b00) begin
        if (pend.size() == 0) fail("mon_rsp_unexpected");
        else begin
          t  = pend.pop_front();
          eq = t.a - t.b;
          check("mon_rsp_idx", 32'(bus.rsp_valid), (t.idx == 1) ? 32'd2 : 32'd1);
          check("mon_rsp_cyc", 32'(cyc), 32'(t.rsp_cyc));
          check("mon_rsp_tmo", 32'(bus.rsp_tmo), 32'(t.tmo));
          check("mon_rsp_div_rst", 32'(bus.div_rst), 32'(t.tmo));
          check("mon_rsp_q", 32'(bus.rsp_q), t.tmo ? 32'd0 : 32'(eq));
          check("mon_rsp_ov", 32'(bus.rsp_ov), t.tmo ? 32'd0 : 32'(t.a < t.b));
          check("mon_rsp_dvz", 32'(bus.rsp_dvz), t.tmo ? 32'd0 : 32'(t.b == '0));
        end
      end
    end
    prev_req = bus.req;
    pa0 = bus.a0; pb0 = bus.b0; pa1 = bus.a1; pb1 = bus.b1;
  end

  task automatic wait_gnt(output logic [1:0] g);
    g = '0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.gnt != 2'b00) begin
        g = bus.gnt;
        return;
      end
    end
    fail("wait_gnt_timeout");
  endtask

  task automatic wait_rsp(output logic [1:0] r);
    r = '0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.rsp_valid != 2'b00) begin
        r = bus.rsp_valid;
        return;
      end
    end
    fail("wait_rsp_timeout");
  endtask

  typedef struct {
    int           idx;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           L;
    logic [W-1:0] q;
    logic         ov;
    logic         dvz;
    logic         tmo;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL global_time_limit");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t       vt[7];
    logic [1:0] g, r, add;
    int         n;

    vt[0] = '{0, 10'b1001010010, 10'b0001100100, 5,    10'b0111101110, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1, 10'd5,          10'd0,          3,    10'd5,          1'b0, 1'b1, 1'b0};
    vt[2] = '{0, 10'd3,          10'd7,          1,    10'd1020,       1'b1, 1'b0, 1'b0};
    vt[3] = '{1, 10'd1023,       10'd1,          63,   10'd1022,       1'b0, 1'b0, 1'b0};
    vt[4] = '{0, 10'd100,        10'd50,         64,   10'd0,          1'b0, 1'b0, 1'b1};
    vt[5] = '{0, 10'd77,         10'd33,         1000, 10'd0,          1'b0, 1'b0, 1'b1};
    vt[6] = '{1, 10'd20,         10'd4,          2,    10'd16,         1'b0, 1'b0, 1'b0};

    bus.req = '0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_div_rst", 32'(bus.div_rst), 32'd1);
    check("rst_loading_done", 32'(bus.div_loading_done), 32'd0);
    check("rst_div_start", 32'(bus.div_start), 32'd0);
    check("rst_ld_a", 32'(bus.div_ld_a), 32'd0);
    check("rst_rsp_q", 32'(bus.rsp_q), 32'd0);
    check("rst_rsp_tmo", 32'(bus.rsp_tmo), 32'd0);
    check("rst_div_a", 32'(bus.div_a), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rel_div_rst", 32'(bus.div_rst), 32'd0);

    // Vector table: single requester, varied latency, dvz, overflow, watchdog boundary
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      stub_L = vt[i].L;
      if (vt[i].idx == 0) begin
        bus.a0 = vt[i].a; bus.b0 = vt[i].b; bus.req = 2'b01;
      end else begin
        bus.a1 = vt[i].a; bus.b1 = vt[i].b; bus.req = 2'b10;
      end
      wait_gnt(g);
      check("tbl_gnt", 32'(g), (vt[i].idx == 1) ? 32'd2 : 32'd1);
      @(posedge clk); #1;
      bus.req = '0;
      bus.a0 = 10'h2AA; bus.b0 = 10'h155; bus.a1 = 10'h3C3; bus.b1 = 10'h0F0;
      wait_rsp(r);
      check("tbl_rsp_valid", 32'(r), (vt[i].idx == 1) ? 32'd2 : 32'd1);
      check("tbl_rsp_q", 32'(bus.rsp_q), 32'(vt[i].q));
      check("tbl_rsp_ov", 32'(bus.rsp_ov), 32'(vt[i].ov));
      check("tbl_rsp_dvz", 32'(bus.rsp_dvz), 32'(vt[i].dvz));
      check("tbl_rsp_tmo", 32'(bus.rsp_tmo), 32'(vt[i].tmo));
      check("tbl_div_rst", 32'(bus.div_rst), 32'(vt[i].tmo));
      repeat (3) @(negedge clk);
      check("tbl_q_hold", 32'(bus.rsp_q), 32'(vt[i].q));
      check("tbl_tmo_hold", 32'(bus.rsp_tmo), 32'(vt[i].tmo));
      check("tbl_idle_busy", 32'(bus.busy), 32'd0);
    end

    // Continuous contention: strict alternation, each response for its own operands
    @(posedge clk); #1;
    stub_L = 4;
    bus.a0 = 10'd300; bus.b0 = 10'd20; bus.a1 = 10'd50; bus.b1 = 10'd7;
    bus.req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(g);
      check("rr_gnt", 32'(g), (k % 2 != 0) ? 32'd2 : 32'd1);
      if (k == 3) begin
        @(posedge clk); #1 bus.req = '0;
      end
      wait_rsp(r);
      check("rr_rsp_valid", 32'(r), (k % 2 != 0) ? 32'd2 : 32'd1);
      check("rr_rsp_q", 32'(bus.rsp_q), (k % 2 != 0) ? 32'd43 : 32'd280);
    end

    // Reset during WAIT aborts without a response
    @(posedge clk); #1;
    stub_L = 30;
    bus.a0 = 10'd200; bus.b0 = 10'd3; bus.req = 2'b01;
    wait_gnt(g);
    @(posedge clk); #1 bus.req = '0;
    repeat (5) @(negedge clk);
    check("t5_wait_loading_done", 32'(bus.div_loading_done), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("t5_div_rst", 32'(bus.div_rst), 32'd1);
    check("t5_loading_done", 32'(bus.div_loading_done), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.rsp_valid != 2'b00) n++;
    end
    check("t5_no_rsp", 32'(n), 32'd0);
    @(posedge clk); #1;
    stub_L = 3;
    bus.a1 = 10'd9; bus.b1 = 10'd2; bus.req = 2'b10;
    wait_gnt(g);
    check("t5_req1_alone", 32'(g), 32'd2);
    @(posedge clk); #1 bus.req = '0;
    wait_rsp(r);
    check("t5_req1_q", 32'(bus.rsp_q), 32'd7);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    bus.a0 = 10'd40; bus.b0 = 10'd8; bus.a1 = 10'd1; bus.b1 = 10'd1;
    bus.req = 2'b11;
    wait_gnt(g);
    check("t5_both_after_rst", 32'(g), 32'd1);
    @(posedge clk); #1 bus.req = 2'b10;
    wait_rsp(r);
    check("t5_both_q0", 32'(bus.rsp_q), 32'd32);
    wait_gnt(g);
    check("t5_then_req1", 32'(g), 32'd2);
    @(posedge clk); #1 bus.req = '0;
    wait_rsp(r);
    check("t5_then_q1", 32'(bus.rsp_q), 32'd0);

    // Random traffic, checked by the monitor
    for (int it = 0; it < 40; it++) begin
      @(posedge clk); #1;
      add    = 2'($urandom_range(1, 3));
      stub_L = ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(1, 70));
      if (add[0] && !bus.req[0]) begin
        bus.a0 = W'($urandom);
        bus.b0 = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
      end
      if (add[1] && !bus.req[1]) begin
        bus.a1 = W'($urandom);
        bus.b1 = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
      end
      bus.req = bus.req | add;
      wait_gnt(g);
      @(posedge clk); #1;
      bus.req = bus.req & ~g;
      if (g[0]) bus.a0 = W'($urandom);
      if (g[1]) bus.a1 = W'($urandom);
      wait_rsp(r);
    end
    if (bus.req != 2'b00) begin
      wait_gnt(g);
      @(posedge clk); #1 bus.req = '0;
      wait_rsp(r);
    end
    repeat (5) @(negedge clk);
    check("end_no_pending", 32'(pend.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
